// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared FSM encoding and widths for the latency-modelled line memory
package data_memory_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_e;
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = 8;
endpackage

// File: rtl/data_memory_array.sv
// data_memory_array: line storage with synchronous write and registered synchronous read
module data_memory_array #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LINE_W     = data_memory_pkg::LINE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [LINE_W-1:0]     wdata_i,
  output logic [LINE_W-1:0]     rdata_o
);
  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [LINE_W-1:0] rdata_q;
  // Storage is deliberately unreset; only the read register clears.
  always_ff @(posedge clk_i)
    if (we_i) mem_q[idx_i] <= wdata_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory_lat.sv
// data_memory_lat: backing line memory that acks each request a fixed LATENCY cycles after capture
module data_memory_lat #(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 9,
  parameter int LINE_W     = data_memory_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);
  import data_memory_pkg::*;
  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wr_q;
  logic [LINE_W-1:0]     wdata_q;
  logic                  ack_q;
  logic                  fire;
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+OFFSET_W], addr_i[OFFSET_W-1:0]};
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else
      case (state_q)
        IDLE: if (enable_i) begin
          idx_q   <= addr_i[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
          wr_q    <= write_i;
          wdata_q <= data_i;
          cnt_q   <= CNT_W'(LATENCY - 1);
          state_q <= BUSY;
        end
        BUSY: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          ack_q   <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
  // The array access happens on the same edge that raises ack.
  assign fire  = state_q == BUSY && cnt_q == '0;
  assign ack_o = ack_q;
  data_memory_array #(.DEPTH_LOG2(DEPTH_LOG2), .LINE_W(LINE_W)) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (fire && wr_q),
    .re_i   (fire && !wr_q),
    .idx_i  (idx_q),
    .wdata_i(wdata_q),
    .rdata_o(data_o)
  );
endmodule

// File: tb/tb_data_memory_lat.sv
// tb_data_memory_lat: LATENCY=10 and LATENCY=1 instances checked against a line-array reference model
module tb_data_memory_lat;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   en = '0, wr = '0, ack;
  logic [31:0]  addr [2];
  logic [255:0] din [2], dout [2];
  logic [255:0] mem [2][512];
  logic [255:0] exp_dout [2];
  int           cyc = 0;
  int           n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_lat #(.LATENCY(10)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(din[0]),
    .enable_i(en[0]), .write_i(wr[0]), .ack_o(ack[0]), .data_o(dout[0])
  );
  data_memory_lat #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(din[1]),
    .enable_i(en[1]), .write_i(wr[1]), .ack_o(ack[1]), .data_o(dout[1])
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] pat(input int i);
    logic [31:0] w;
    w = {16'hA5A5, 16'(i)};
    return {8{w}};
  endfunction

  // One request on instance d, started just after a clock edge; returns the cycle of its ack.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [255:0] wd,
                      input bit keep, input bit drop, output int t_ack);
    int n, i, lat;
    lat = d == 1 ? 1 : 10;
    i = int'((a >> 5) & 32'h1FF);
    en[d] = 1'b1; wr[d] = w; addr[d] = a; din[d] = wd;
    @(posedge clk); #1;
    if (drop) begin
      en[d] = 1'b0; wr[d] = $urandom; addr[d] = $urandom; din[d] = rnd256();
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[d] && n < 300);
    t_ack = cyc;
    check(d ? "latency1" : "latency10", 256'(n), 256'(lat));
    if (w) mem[d][i] = wd;
    else exp_dout[d] = mem[d][i];
    check(w ? "dout_on_write_ack" : "read_data", dout[d], exp_dout[d]);
    if (!keep) en[d] = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 256'(ack[d]), 256'(0));
  endtask

  initial begin
    int t1, t2, d;
    logic [255:0] v;
    addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
    exp_dout[0] = '0; exp_dout[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 256'(ack), 256'(0));
    check("reset_dout0", dout[0], 256'(0));
    check("reset_dout1", dout[1], 256'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 512; i++) begin
      xfer(0, 1'b1, 32'(i) << 5, pat(i), 1'b0, 1'b0, t1);
      xfer(1, 1'b1, 32'(i) << 5, pat(i), 1'b0, 1'b0, t1);
    end
    xfer(0, 1'b0, 32'h0000_0060, '0, 1'b0, 1'b0, t1);
    check("line3_preload", dout[0], {8{32'hA5A5_0003}});
    xfer(0, 1'b0, 32'h0000_007C, '0, 1'b0, 1'b0, t1);
    check("offset_ignored", dout[0], {8{32'hA5A5_0003}});
    v = {4{64'h1234_5678_9ABC_CDEF}};
    xfer(0, 1'b1, 32'h0000_0120, v, 1'b0, 1'b0, t1);
    xfer(0, 1'b0, 32'h0000_0120, '0, 1'b0, 1'b0, t1);
    check("write_then_read", dout[0], v);
    v = rnd256();
    xfer(0, 1'b1, 32'h0000_4020, v, 1'b1, 1'b0, t1);
    xfer(0, 1'b0, 32'h0000_8020, '0, 1'b0, 1'b0, t2);
    check("wb_refill_gap", 256'(t2 - t1), 256'(12));
    check("wb_refill_data", dout[0], v);
    xfer(1, 1'b0, 32'h0000_3FE0, '0, 1'b0, 1'b0, t1);
    check("line511", dout[1], pat(511));
    xfer(1, 1'b0, 32'h0000_4000, '0, 1'b0, 1'b0, t1);
    check("wrap_line0", dout[1], pat(0));
    // Abort a write to line 7 mid-flight; the line must keep its old contents.
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_00E0; din[0] = rnd256();
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1; rst = 1'b0; #1;
    en[0] = 1'b0;
    check("abort_ack", 256'(ack), 256'(0));
    check("abort_dout0", dout[0], 256'(0));
    check("abort_dout1", dout[1], 256'(0));
    exp_dout[0] = '0; exp_dout[1] = '0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_idle", 256'(ack), 256'(0));
    xfer(0, 1'b0, 32'h0000_00E0, '0, 1'b0, 1'b0, t1);
    check("abort_line7_kept", dout[0], pat(7));
    xfer(1, 1'b0, 32'h0000_00E0, '0, 1'b0, 1'b0, t1);
    repeat (150) begin
      d = int'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) begin
        xfer(d, 1'b1, $urandom, rnd256(), 1'b1, 1'b0, t1);
        xfer(d, 1'b0, $urandom, '0, 1'b0, 1'b0, t2);
        check("rand_b2b_gap", 256'(t2 - t1), 256'(d ? 3 : 12));
      end else
        xfer(d, 1'($urandom), $urandom, rnd256(), 1'b0, $urandom_range(3, 0) == 0, t1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
